// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame_capture receiver: FSM states,
// default geometry/width constants and the {R,G,B} pixel unpacking helper.
package frame_capture_pkg;

  localparam int DEF_PIXSIZE = 8;
  localparam int DEF_COLS    = 640;
  localparam int DEF_ROWS    = 480;
  localparam int DEF_ADDR_W  = 19;
  localparam int CFG_W       = 16;
  localparam int RGB_W       = 3 * DEF_PIXSIZE;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_SOF,
    CAPTURE,
    END
  } state_e;

  typedef struct packed {
    logic [DEF_PIXSIZE-1:0] r;
    logic [DEF_PIXSIZE-1:0] g;
    logic [DEF_PIXSIZE-1:0] b;
  } rgb_t;

  // Red travels in the MSBs, so the first struct member lines up with it.
  function automatic rgb_t unpack_rgb(input logic [RGB_W-1:0] data);
    return rgb_t'(data);
  endfunction

endpackage

// File: rtl/frame_capture_xy.sv
// Raster position tracker: column/row counters plus a linear write address
// that advances by one per written pixel, cleared between frames.
module xy_counter
  import frame_capture_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  localparam int XW    = $clog2(COLS + 1),
  localparam int YW    = $clog2(ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [CFG_W-1:0]  cfg_width_i,
  output logic [XW-1:0]     x_o,
  output logic [YW-1:0]     y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_o
);

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;

  assign tc_o   = (x_q == XW'(cfg_width_i - 16'd1));
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (inc_i) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (tc_o) begin
        x_q <= '0;
        y_q <= y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// Frame-buffer writer for a frame_valid/line_valid RGB stream: captures one
// frame per arm (or continuously), writes raster-addressed pixels, checks size.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int PIXSIZE = DEF_PIXSIZE,
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 cont,
  input  logic [15:0]          cfg_width,
  input  logic [15:0]          cfg_height,
  input  logic                 frame_valid,
  input  logic                 line_valid,
  input  logic [3*PIXSIZE-1:0] rgb_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [PIXSIZE-1:0]   wr_red,
  output logic [PIXSIZE-1:0]   wr_green,
  output logic [PIXSIZE-1:0]   wr_blue,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ADDR_W:0]      pix_count,
  output logic                 err_short,
  output logic                 err_long
);

  localparam int CW = ADDR_W + 1;
  localparam int XW = $clog2(COLS + 1);
  localparam int YW = $clog2(ROWS + 1);

  state_e            state_q;
  logic [15:0]       width_q;
  logic [CW-1:0]     limit_q;
  logic [CW-1:0]     pix_count_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  rgb_t              pix_q;
  logic              frame_done_q;
  logic              err_short_q;
  logic              err_long_q;

  rgb_t              px;
  logic              pix_valid;
  logic              sof;
  logic              in_frame;
  logic              room;
  logic              wr_d;
  logic              cnt_clr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              tc;
  logic              unused_xy;

  assign px        = unpack_rgb(rgb_data);
  assign pix_valid = frame_valid & line_valid;
  // A 1-cycle frame_valid gap in cont mode lands the next rise on END.
  assign sof       = frame_valid & ((state_q == WAIT_SOF) | ((state_q == END) & cont));
  assign in_frame  = (state_q == CAPTURE) & frame_valid;
  assign room      = sof | (pix_count_q < limit_q);
  assign wr_d      = pix_valid & (sof | in_frame) & room;
  assign cnt_clr   = ((state_q == IDLE) & arm) | ((state_q == CAPTURE) & ~frame_valid);
  assign unused_xy = ^{x, y, tc};

  xy_counter #(
    .ADDR_W (ADDR_W),
    .COLS   (COLS),
    .ROWS   (ROWS)
  ) u_xy (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cnt_clr),
    .inc_i       (wr_d),
    .cfg_width_i (width_q),
    .x_o         (x),
    .y_o         (y),
    .addr_o      (addr),
    .tc_o        (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      limit_q      <= '0;
      pix_count_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      wr_en_q      <= wr_d;
      frame_done_q <= 1'b0;
      if (wr_d) begin
        wr_addr_q <= addr;
        pix_q     <= px;
      end
      unique case (state_q)
        IDLE: if (arm) begin
          width_q     <= cfg_width;
          limit_q     <= CW'(cfg_width) * CW'(cfg_height);
          pix_count_q <= '0;
          err_short_q <= 1'b0;
          err_long_q  <= 1'b0;
          state_q     <= SYNC;
        end
        SYNC: if (!frame_valid) state_q <= WAIT_SOF;
        WAIT_SOF: if (frame_valid) begin
          pix_count_q <= CW'(pix_valid);
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          if (!frame_valid) begin
            frame_done_q <= 1'b1;
            err_short_q  <= (pix_count_q < limit_q);
            err_long_q   <= (pix_count_q > limit_q);
            state_q      <= END;
          end else if (pix_valid && pix_count_q <= limit_q) begin
            // Saturating one past the limit is what marks a long frame.
            pix_count_q <= pix_count_q + CW'(1);
          end
        end
        END: begin
          if (!cont) begin
            state_q <= IDLE;
          end else if (frame_valid) begin
            pix_count_q <= CW'(pix_valid);
            state_q     <= CAPTURE;
          end else begin
            state_q <= WAIT_SOF;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_red     = pix_q.r;
  assign wr_green   = pix_q.g;
  assign wr_blue    = pix_q.b;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture: table-driven frames, randomized
// frames against a queue-based model, and hand sequences for corner cases.
module tb_frame_capture;

  logic        clk = 1'b0;
  logic        rst_n, arm, cont, frame_valid, line_valid;
  logic [15:0] cfg_width, cfg_height;
  logic [23:0] rgb_data;
  logic        wr_en, busy, frame_done, err_short, err_long;
  logic [18:0] wr_addr;
  logic [7:0]  wr_red, wr_green, wr_blue;
  logic [19:0] pix_count;

  always #5 clk = ~clk;

  frame_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .cont        (cont),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .rgb_data    (rgb_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_red      (wr_red),
    .wr_green    (wr_green),
    .wr_blue     (wr_blue),
    .busy        (busy),
    .frame_done  (frame_done),
    .pix_count   (pix_count),
    .err_short   (err_short),
    .err_long    (err_long)
  );

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int w, h, n, pmod, ppos, plen, exp_cnt;
    bit exp_short, exp_long;
    int exp_wr;
  } vec_t;

  int  cyc = 0;
  int  done_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  wr_t mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      mon_w.addr = int'(wr_addr);
      mon_w.data = {wr_red, wr_green, wr_blue};
      mon_w.cyc  = cyc;
      got_q.push_back(mon_w);
    end
    if (frame_done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pat(input int i);
    return {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)};
  endfunction

  task automatic do_arm(input int w, input int h);
    arm = 1'b1; cfg_width = 16'(w); cfg_height = 16'(h);
    line_valid = 1'($urandom_range(0, 1));
    tick();
    check("arm busy", busy, 1);
    arm = 1'b0;
    cfg_width = 16'($urandom_range(1, 640)); cfg_height = 16'($urandom_range(1, 480));
    line_valid = 1'($urandom_range(0, 1));
    tick();
  endtask

  // Drives n pixels; the model expects write i at address i for i < lim,
  // visible the cycle after the edge that samples the pixel.
  task automatic drive_frame(input int n, input int lim, input int pmod, input int ppos,
                             input int plen, input bit rnd, input bit capture);
    wr_t e;
    int  pl;
    for (int i = 0; i < n; i++) begin
      frame_valid = 1'b1;
      line_valid  = 1'b1;
      rgb_data    = rnd ? 24'($urandom) : pat(i);
      if (capture && i < lim) begin
        e.addr = i; e.data = rgb_data; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      arm = rnd && (i == n / 2);
      if (arm) cfg_width = 16'($urandom_range(1, 640));
      tick();
      arm = 1'b0;
      pl = 0;
      if (rnd) pl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      else if (pmod != 0 && (i % pmod) == ppos) pl = plen;
      for (int k = 0; k < pl; k++) begin
        line_valid = 1'b0;
        rgb_data   = 24'($urandom);
        tick();
      end
    end
    frame_valid = 1'b0;
    line_valid  = 1'($urandom_range(0, 1));
    rgb_data    = 24'($urandom);
    tick();
  endtask

  task automatic end_checks(input string name, input int cnt, input bit es, input bit el);
    check({name, " frame_done"}, frame_done, 1);
    check({name, " pix_count"}, pix_count, 64'(cnt));
    check({name, " err_short"}, err_short, es);
    check({name, " err_long"}, err_long, el);
  endtask

  task automatic compare_writes(input string name);
    int n;
    check({name, " wr_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, " wr_addr"}, got_q[i].addr, exp_q[i].addr);
      check({name, " wr_data"}, got_q[i].data, exp_q[i].data);
      check({name, " wr_cycle"}, got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int w, h, lim, n, cnt, done0;
    vecs[0] = '{4, 2, 8, 0, 0, 0, 8, 0, 0, 8};
    vecs[1] = '{8, 2, 16, 8, 3, 5, 16, 0, 0, 16};
    vecs[2] = '{4, 2, 6, 0, 0, 0, 6, 1, 0, 6};
    vecs[3] = '{4, 2, 10, 0, 0, 0, 9, 0, 1, 8};
    vecs[4] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 1};
    vecs[5] = '{1, 1, 3, 0, 0, 0, 2, 0, 1, 1};
    vecs[6] = '{5, 3, 15, 2, 1, 1, 15, 0, 0, 15};
    vecs[7] = '{640, 1, 640, 0, 0, 0, 640, 0, 0, 640};
    vecs[8] = '{3, 4, 11, 4, 0, 2, 11, 1, 0, 11};

    rst_n = 1'b0; arm = 1'b0; cont = 1'b0; cfg_width = '0; cfg_height = '0;
    frame_valid = 1'b0; line_valid = 1'b0; rgb_data = '0;
    tick(); tick();
    check("reset wr", {wr_en, wr_addr, wr_red, wr_green, wr_blue}, 0);
    check("reset status", {busy, frame_done, pix_count, err_short, err_long}, 0);
    rst_n = 1'b1;
    tick();
    check("idle busy", busy, 0);

    foreach (vecs[v]) begin
      do_arm(vecs[v].w, vecs[v].h);
      drive_frame(vecs[v].n, vecs[v].w * vecs[v].h, vecs[v].pmod, vecs[v].ppos,
                  vecs[v].plen, 1'b0, 1'b1);
      end_checks("table", vecs[v].exp_cnt, vecs[v].exp_short, vecs[v].exp_long);
      tick();
      check("table done pulse", frame_done, 0);
      check("table idle", busy, 0);
      check("table writes", got_q.size(), vecs[v].exp_wr);
      compare_writes("table");
    end

    for (int r = 0; r < 20; r++) begin
      w   = $urandom_range(1, 8);
      h   = $urandom_range(1, 4);
      lim = w * h;
      n   = $urandom_range(lim + 3, (lim > 3) ? lim - 3 : 1);
      cnt = (n > lim) ? lim + 1 : n;
      do_arm(w, h);
      drive_frame(n, lim, 0, 0, 0, 1'b1, 1'b1);
      end_checks("rand", cnt, n < lim, n > lim);
      tick();
      check("rand done pulse", frame_done, 0);
      compare_writes("rand");
    end

    // Arm while a frame is already running: that frame must be skipped.
    frame_valid = 1'b1; line_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rgb_data = 24'($urandom); tick(); end
    arm = 1'b1; cfg_width = 16'd4; cfg_height = 16'd2;
    tick();
    arm = 1'b0;
    check("midarm busy", busy, 1);
    for (int i = 0; i < 6; i++) begin rgb_data = 24'($urandom); tick(); end
    check("midarm no writes", got_q.size(), 0);
    frame_valid = 1'b0; line_valid = 1'b0;
    tick();
    check("midarm no done", frame_done, 0);
    drive_frame(8, 8, 0, 0, 0, 1'b0, 1'b1);
    end_checks("midarm next", 8, 0, 0);
    tick();
    compare_writes("midarm");

    // Continuous mode, back-to-back 4x1 frames with a single low cycle.
    cont  = 1'b1;
    done0 = done_cnt;
    do_arm(4, 1);
    drive_frame(4, 4, 0, 0, 0, 1'b0, 1'b1);
    end_checks("cont A", 4, 0, 0);
    drive_frame(4, 4, 0, 0, 0, 1'b1, 1'b1);
    end_checks("cont B", 4, 0, 0);
    tick();
    check("cont done pulses", done_cnt - done0, 2);
    check("cont still busy", busy, 1);
    compare_writes("cont");

    // Reset after pixel 2 of a frame captured from WAIT_SOF.
    cont = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_t e;
      frame_valid = 1'b1; line_valid = 1'b1; rgb_data = pat(i + 40);
      e.addr = i; e.data = rgb_data; e.cyc = cyc + 1;
      exp_q.push_back(e);
      tick();
    end
    rst_n = 1'b0; rgb_data = pat(43);
    tick();
    check("midrst wr", {wr_en, wr_addr, wr_red, wr_green, wr_blue}, 0);
    check("midrst status", {busy, frame_done, pix_count, err_short, err_long}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin rgb_data = 24'($urandom); tick(); end
    frame_valid = 1'b0;
    tick();
    check("midrst idle", busy, 0);
    check("midrst no done", frame_done, 0);
    compare_writes("midrst");
    do_arm(4, 2);
    drive_frame(8, 8, 0, 0, 0, 1'b1, 1'b1);
    end_checks("postrst", 8, 0, 0);
    tick();
    compare_writes("postrst");

    check("total frame_done", done_cnt, 33);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
# frame_capture

Synthesizable receiver for the frame_valid / line_valid / RGB pixel stream produced by the image-sensor emulator and the IP16 processing chain. It samples qualified pixels, assigns them raster addresses and issues single-cycle writes to the frame buffers (red/green/blue memories). It also checks frame geometry against a configured width and height and reports completion and short/long-frame errors. It sits at the output of the processing pipeline, in place of the testbench memories on hardware, and as a checker in simulation.

## Interface
- PIXSIZE, 8 — bits per colour component; equal to D16_PIXSIZE.
- COLS, 640 — maximum image width; equal to D16_COLS.
- ROWS, 480 — maximum image height; equal to D16_ROWS.
- ADDR_W, 19 — write-address width; must satisfy 2^ADDR_W >= ROWS*COLS.

- clk  in  1  — single clock; all logic is rising-edge.
- rst_n  in  1  — reset; synchronous and active-low.
- arm  in  1  — one-cycle request to capture the next complete frame.
- cont  in  1  — continuous mode: re-arms automatically after each frame.
- cfg_width  in  16  — active pixels per line; sampled when arm is accepted; 1..COLS.
- cfg_height  in  16  — active lines per frame; sampled when arm is accepted; 1..ROWS.
- frame_valid  in  1  — frame qualifier.
- line_valid  in  1  — pixel qualifier; may drop mid-line to create pauses.
- rgb_data  in  3*PIXSIZE  — pixel as {R,G,B}, with R in the MSBs.
- wr_en  out  1  — frame-buffer write strobe.
- wr_addr  out  ADDR_W  — linear raster address: y*cfg_width + x.
- wr_red / wr_green / wr_blue  out  PIXSIZE each  — component write data.
- busy  out  1  — high in every state except IDLE.
- frame_done  out  1  — one-cycle pulse at end of frame.
- pix_count  out  ADDR_W+1  — accepted pixels in the last or current frame.
- err_short  out  1  — last frame delivered fewer than width*height pixels.
- err_long  out  1  — last frame delivered more than width*height pixels.

## Operation
- Pixel accepted ⇔ frame_valid & line_valid, sampled at the rising edge of clk in CAPTURE. Line boundaries come from the column counter only. A line_valid drop is a pause, not an end of line.
- States and transitions:
  - IDLE:
    - arm → SYNC. cfg_width and cfg_height are latched, pix_count and the error flags are cleared.
  - SYNC: discards any frame already in progress.
    - frame_valid==0 → WAIT_SOF.
  - WAIT_SOF:
    - frame_valid==1 → CAPTURE. If line_valid is also 1 in that cycle, the pixel is accepted as pixel (0,0).
  - CAPTURE:
    - Each accepted pixel increments x.
    - x == cfg_width-1 wraps x to 0 and increments y.
    - frame_valid==0 → END.
  - END (one cycle):
    - frame_done=1; err_short / err_long are set from the final count.
    - Next state is WAIT_SOF if cont=1, otherwise IDLE.
- Overflow:
  - Once pix_count reaches cfg_width*cfg_height, further pixels are not written.
  - pix_count saturates at cfg_width*cfg_height+1, which flags err_long.
- arm outside IDLE is ignored. cfg_* changes outside IDLE have no effect.
- A pixel with frame_valid=0 is never accepted, even if line_valid=1.
- Reset (any state, including mid-frame):
  - All outputs go to 0 and the state goes to IDLE.
  - After re-arm, the interrupted frame is skipped through SYNC.

## Timing
- Write latency is 1 cycle: a pixel sampled at edge N gives wr_en=1 with its address and data during cycle N+1, registered.
- Throughput: one pixel per clock. Pauses of any length are tolerated.
- The frame_valid fall sampled at edge N makes frame_done high during cycle N+1. The error flags are valid in the same cycle and hold until the next accepted arm (or, in cont mode, the next END).
- Back-to-back frames:
  - A frame_valid rise one cycle after frame_done, in cont mode, must be captured.
  - The minimum frame_valid-low gap is 1 cycle.
- Reset values: wr_en, wr_addr, wr_red/green/blue, busy, frame_done, pix_count, err_short and err_long are all 0.

## Structure
- Package frame_capture_pkg holds:
  - the state enum (IDLE, SYNC, WAIT_SOF, CAPTURE, END);
  - width constants derived from PIXSIZE, COLS and ROWS;
  - a function that unpacks rgb_data into its components.
- One sub-module, xy_counter. Inputs: cfg_width, an increment, a clear. Outputs: x, y, a linear address and a terminal-count flag. It is instantiated once in frame_capture.

## Test plan
- Single 4x2 frame, no pauses:
  - Stimulus: arm with width=4, height=2; stream pixels 0x010203..0x161718.
  - Response: 8 writes at addresses 0..7 with matching R/G/B; frame_done one cycle after the frame_valid fall; pix_count=8; no errors.
- Paused line:
  - Stimulus: 8x2 frame with line_valid low for 5 cycles after pixel 3 and after pixel 11.
  - Response: addresses remain contiguous 0..15; no writes during the pauses.
- Arm mid-frame:
  - Stimulus: arm while frame_valid is already high.
  - Response: no writes for that frame; the following frame is captured from address 0.
- Short and long frames:
  - Stimulus (width=4, height=2): one frame of 6 pixels, then one of 10.
  - Response: first frame gives err_short=1, pix_count=6. Second gives err_long=1, only addresses 0..7 written, pix_count=9.
- Continuous back-to-back:
  - Stimulus: cont=1, two 4x1 frames separated by a 1-cycle frame_valid gap.
  - Response: two frame_done pulses, 8 writes, both frames at addresses 0..3.
- Reset mid-CAPTURE:
  - Stimulus: rst_n low for 1 cycle after pixel 2 of a frame.
  - Response: the next cycle shows all outputs 0 and busy=0; no further writes until the next arm.
